weight_loader_1x8: RTL and testbench
====================================

Name: weight_loader_1x8

Overview:
- Write-side sequencer for the 8-bank, 72-bit weight buffer.
- Accepts a valid/ready stream of 72-bit weight words, typically 8 packed 9-bit weights from the DMA/unpacker.
- Steers each word to one of 8 banks and generates the per-bank write address and write enable.
- Banks are filled in bank-major order: words_per_bank words to bank 0, then bank 1, through bank 7. A done pulse is issued when the tile is fully loaded.

Parameters:
- DEPTH, 512, words per bank.
- ADDR_BIT, 9, bank address width; 2^ADDR_BIT >= DEPTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle load command; sampled only in IDLE.
- base_addr  in  ADDR_BIT  first bank address; captured on start.
- words_per_bank  in  ADDR_BIT+1  words per bank (0..DEPTH); captured on start.
- s_valid  in  1  input word valid.
- s_data  in  72  input weight word.
- s_ready  out  1  loader can accept a word.
- write_addr_0 .. write_addr_7  out  ADDR_BIT each  bank write addresses; all 8 carry the same value.
- write_en_0 .. write_en_7  out  1 each  bank write enables; one-hot or zero.
- weight_wr_data  out  72  shared write data to all banks.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when the tile is complete.

Behaviour:
- Reset, asynchronous and immediate:
  - state=IDLE.
  - All write_en_k=0, write_addr_k=0, weight_wr_data=0.
  - s_ready=0, busy=0, done=0.
  - Internal counters cleared.
  - Reset mid-load abandons the tile; no further writes occur and no done pulse is issued.
- States: IDLE, LOAD, DONE.
- IDLE:
  - On start=1, capture base_addr and words_per_bank. A value above DEPTH saturates to DEPTH.
  - Clear bank_idx=0 and word_cnt=0.
  - If the captured count is 0, go to DONE with no writes. Otherwise go to LOAD.
- LOAD:
  - s_ready=1 combinationally while state==LOAD; 0 in every other state.
  - A handshake is s_valid&&s_ready at cycle T. At cycle T+1, registered:
    - write_en_[bank_idx]=1, all other write_en=0.
    - write_addr_k = (base_addr + word_cnt) mod 2^ADDR_BIT, for all k.
    - weight_wr_data = s_data.
  - Write latency is exactly 1 cycle.
  - write_en is 0 in any cycle following no handshake. write_addr and weight_wr_data hold their last values.
  - After a handshake, word_cnt increments.
  - When word_cnt reaches count-1 on a handshake, word_cnt returns to 0 and bank_idx increments.
  - The handshake on bank 7's last word moves state to DONE.
  - s_valid gaps are allowed at any point and stall progress without side effects.
- DONE:
  - Lasts exactly 1 cycle, with done=1 and busy=1.
  - The last word's write_en pulse and done are asserted in the same cycle.
  - Next state is IDLE.
- start is ignored while busy=1, including in the DONE cycle. The earliest accepted restart is the first IDLE cycle.
- Address wrap: base_addr+word_cnt wraps modulo 2^ADDR_BIT. Base and count are the caller's responsibility; no overflow flag.
- busy goes high the cycle after an accepted start and low the cycle after done.

Test Plan:
- Basic tile:
  - Stimulus: start with base=0, wpb=4; 32 back-to-back words with s_data=i.
  - Required: bank k receives data 4k..4k+3 at addr 0..3; write_en is one-hot every cycle; done is high with the 32nd write_en; busy spans 33 cycles.
- Backpressure gaps:
  - Stimulus: same tile, s_valid toggled 1,0,0,1...
  - Required: write_en is asserted only the cycle after each handshake; the address/data sequence is identical to the basic tile; no extra writes.
- Base offset and wrap:
  - Stimulus: base=510, wpb=4, ADDR_BIT=9.
  - Required: each bank is written at addresses 510, 511, 0, 1.
- Zero and saturation:
  - Stimulus: wpb=0.
  - Required: no write_en; done pulses 1 cycle after start; s_ready never rises.
  - Stimulus: wpb=600.
  - Required: 512 writes per bank, 4096 total.
- Start while busy:
  - Stimulus: a second start pulse mid-load and another in the DONE cycle.
  - Required: both are ignored; the tile completes unchanged; a start on the following IDLE cycle is accepted.
- Reset mid-load:
  - Stimulus: assert rst after 10 handshakes.
  - Required: all outputs are 0 immediately, with no done pulse; a new start after release loads a full fresh tile from bank 0, addr base.

Source files
------------

// File: rtl/weight_loader_1x8.sv
// Write-side sequencer for the 8-bank weight buffer: steers a valid/ready stream of 72-bit words
// into banks 0..7 in bank-major order and pulses done when the tile is loaded.
module weight_loader_1x8 #(
  parameter int unsigned DEPTH    = 512,
  parameter int unsigned ADDR_BIT = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_BIT-1:0] base_addr,
  input  logic [ADDR_BIT:0]   words_per_bank,
  input  logic                s_valid,
  input  logic [71:0]         s_data,
  output logic                s_ready,
  output logic [ADDR_BIT-1:0] write_addr_0,
  output logic [ADDR_BIT-1:0] write_addr_1,
  output logic [ADDR_BIT-1:0] write_addr_2,
  output logic [ADDR_BIT-1:0] write_addr_3,
  output logic [ADDR_BIT-1:0] write_addr_4,
  output logic [ADDR_BIT-1:0] write_addr_5,
  output logic [ADDR_BIT-1:0] write_addr_6,
  output logic [ADDR_BIT-1:0] write_addr_7,
  output logic                write_en_0,
  output logic                write_en_1,
  output logic                write_en_2,
  output logic                write_en_3,
  output logic                write_en_4,
  output logic                write_en_5,
  output logic                write_en_6,
  output logic                write_en_7,
  output logic [71:0]         weight_wr_data,
  output logic                busy,
  output logic                done
);

  localparam logic [ADDR_BIT:0] MaxCnt = (ADDR_BIT + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e              state_q;
  logic [2:0]          bank_q;
  logic [ADDR_BIT:0]   word_q;
  logic [ADDR_BIT:0]   cnt_q;
  logic [ADDR_BIT-1:0] base_q;
  logic [ADDR_BIT-1:0] addr_q;
  logic [71:0]         data_q;
  logic [7:0]          wen_q;
  logic                busy_q;
  logic                done_q;
  logic [ADDR_BIT:0]   cnt_sat;

  always_comb begin
    cnt_sat = (words_per_bank > MaxCnt) ? MaxCnt : words_per_bank;
  end

  assign s_ready = (state_q == StLoad);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      bank_q  <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wen_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // Enables and done are single-cycle pulses unless re-armed below.
      wen_q  <= '0;
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            base_q <= base_addr;
            cnt_q  <= cnt_sat;
            bank_q <= '0;
            word_q <= '0;
            busy_q <= 1'b1;
            if (cnt_sat == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StLoad;
            end
          end
        end
        StLoad: begin
          if (s_valid) begin
            wen_q  <= 8'd1 << bank_q;
            addr_q <= base_q + word_q[ADDR_BIT-1:0];
            data_q <= s_data;
            if (word_q == cnt_q - 1'b1) begin
              word_q <= '0;
              bank_q <= bank_q + 3'd1;
              if (bank_q == 3'd7) begin
                state_q <= StDone;
                done_q  <= 1'b1;
              end
            end else begin
              word_q <= word_q + 1'b1;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign write_addr_0   = addr_q;
  assign write_addr_1   = addr_q;
  assign write_addr_2   = addr_q;
  assign write_addr_3   = addr_q;
  assign write_addr_4   = addr_q;
  assign write_addr_5   = addr_q;
  assign write_addr_6   = addr_q;
  assign write_addr_7   = addr_q;
  assign write_en_0     = wen_q[0];
  assign write_en_1     = wen_q[1];
  assign write_en_2     = wen_q[2];
  assign write_en_3     = wen_q[3];
  assign write_en_4     = wen_q[4];
  assign write_en_5     = wen_q[5];
  assign write_en_6     = wen_q[6];
  assign write_en_7     = wen_q[7];
  assign weight_wr_data = data_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_weight_loader_1x8.sv
// Directed bench for weight_loader_1x8: drives tiles, logs every bank write on the falling edge
// and compares the log with a bank-major address/data model.
module tb_weight_loader_1x8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [8:0]  base_addr = '0;
  logic [9:0]  words_per_bank = '0;
  logic        s_valid = 1'b0;
  logic [71:0] s_data = '0;
  logic        s_ready;
  logic [8:0]  wa0, wa1, wa2, wa3, wa4, wa5, wa6, wa7;
  logic        we0, we1, we2, we3, we4, we5, we6, we7;
  logic [71:0] weight_wr_data;
  logic        busy, done;
  logic [7:0]  wen;

  assign wen = {we7, we6, we5, we4, we3, we2, we1, we0};

  weight_loader_1x8 dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .words_per_bank(words_per_bank), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .write_addr_0(wa0), .write_addr_1(wa1), .write_addr_2(wa2), .write_addr_3(wa3),
    .write_addr_4(wa4), .write_addr_5(wa5), .write_addr_6(wa6), .write_addr_7(wa7),
    .write_en_0(we0), .write_en_1(we1), .write_en_2(we2), .write_en_3(we3),
    .write_en_4(we4), .write_en_5(we5), .write_en_6(we6), .write_en_7(we7),
    .weight_wr_data(weight_wr_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Write log and event counters, owned by the monitor; tasks only read them.
  int         wr_bank[$];
  logic [8:0] wr_addr[$];
  logic [71:0] wr_data[$];
  int  cyc = 0, onehot_err = 0, lat_err = 0, addr_err = 0;
  int  done_cnt = 0, busy_cyc = 0, ready_cyc = 0, done_cyc = 0, last_wr_cyc = 0;
  bit  hs_last = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      hs_last <= 1'b0;
    end else begin
      if ($countones(wen) > 1) onehot_err <= onehot_err + 1;
      if ((wen != 8'd0) != hs_last) lat_err <= lat_err + 1;
      hs_last <= s_valid && s_ready;
      if ({wa1, wa2, wa3, wa4, wa5, wa6, wa7} != {7{wa0}}) addr_err <= addr_err + 1;
      if (wen != 8'd0) begin
        for (int k = 0; k < 8; k++) if (wen[k]) wr_bank.push_back(k);
        wr_addr.push_back(wa0);
        wr_data.push_back(weight_wr_data);
        last_wr_cyc <= cyc + 1;
      end
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc + 1;
      end
      if (busy) busy_cyc <= busy_cyc + 1;
      if (s_ready) ready_cyc <= ready_cyc + 1;
    end
  end

  int s_wr, s_onehot, s_lat, s_addr, s_done, s_busy, s_ready_c, s_cyc;

  // mode: 0 back-to-back, 1 valid pattern 1,0,0, 2 extra starts while busy, 3 reset after 10 words
  task automatic run_tile(input logic [8:0] base, input logic [9:0] wpb, input int mode);
    int total, i, c, budget;
    bit mid, ready_now;
    total = 8 * ((wpb > 10'd512) ? 512 : int'(wpb));
    s_wr = wr_bank.size(); s_onehot = onehot_err; s_lat = lat_err; s_addr = addr_err;
    s_done = done_cnt; s_busy = busy_cyc; s_ready_c = ready_cyc;
    start = 1'b1; base_addr = base; words_per_bank = wpb;
    @(posedge clk); #1;
    start = 1'b0; base_addr = 9'h0AA; words_per_bank = 10'd3;
    s_cyc = cyc;
    i = 0; c = 0; budget = 0; mid = 1'b0;
    while (i < total && !(mode == 3 && i == 10)) begin
      s_valid = (mode != 1) || (c % 3 == 0);
      s_data  = 72'(i);
      if (mode == 2 && i == 10 && !mid) begin
        start = 1'b1; base_addr = 9'd100; words_per_bank = 10'd1; mid = 1'b1;
      end
      @(negedge clk); ready_now = s_ready;
      @(posedge clk);
      if (s_valid && ready_now) i++;
      #1;
      start = 1'b0; base_addr = 9'h0AA; words_per_bank = 10'd3;
      c++; budget++;
      if (budget > 20000) begin
        check_val("feed timeout", 72'(budget), 72'd0);
        break;
      end
    end
    s_valid = 1'b0;
    if (mode == 3) begin
      #1 rst = 1'b1;
      #1;
      check_val("rst wen", 72'(wen), 72'd0);
      check_val("rst addr", 72'(wa0 | wa3 | wa7), 72'd0);
      check_val("rst data", weight_wr_data, 72'd0);
      check_val("rst ready/busy/done", 72'({s_ready, busy, done}), 72'd0);
      check_val("rst no done", 72'(done_cnt - s_done), 72'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      return;
    end
    if (mode == 2) begin
      start = 1'b1; words_per_bank = 10'd0;  // lands in the DONE cycle
    end
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 8 && done_cnt == s_done; k++) begin
      @(posedge clk); #1;
    end
    check_val("busy low after tile", 72'(busy), 72'd0);
  endtask

  task automatic verify(input string tag, input logic [8:0] base, input int eff, input int bspan);
    int n, errs;
    logic [8:0] ea;
    n = wr_bank.size() - s_wr;
    errs = 0;
    check_val({tag, " writes"}, 72'(n), 72'(8 * eff));
    for (int j = 0; j < n && j < 8 * eff; j++) begin
      ea = 9'(int'(base) + j % eff);
      if (wr_bank[s_wr+j] != j / eff || wr_addr[s_wr+j] != ea || wr_data[s_wr+j] != 72'(j))
        errs++;
    end
    check_val({tag, " seq errs"}, 72'(errs), 72'd0);
    check_val({tag, " onehot errs"}, 72'(onehot_err - s_onehot), 72'd0);
    check_val({tag, " latency errs"}, 72'(lat_err - s_lat), 72'd0);
    check_val({tag, " addr port errs"}, 72'(addr_err - s_addr), 72'd0);
    check_val({tag, " done pulses"}, 72'(done_cnt - s_done), 72'd1);
    if (eff > 0) check_val({tag, " done with last write"}, 72'(done_cyc), 72'(last_wr_cyc));
    if (bspan >= 0) check_val({tag, " busy span"}, 72'(busy_cyc - s_busy), 72'(bspan));
  endtask

  initial begin
    #3;
    check_val("reset wen", 72'(wen), 72'd0);
    check_val("reset data", weight_wr_data, 72'd0);
    check_val("reset ready/busy/done", 72'({s_ready, busy, done}), 72'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    run_tile(9'd0, 10'd4, 0);   verify("basic", 9'd0, 4, 33);
    run_tile(9'd0, 10'd4, 1);   verify("gaps", 9'd0, 4, -1);
    run_tile(9'd510, 10'd4, 0); verify("wrap", 9'd510, 4, 33);
    check_val("wrap bank1 third addr", 72'(wr_addr[s_wr+6]), 72'd0);

    run_tile(9'd0, 10'd0, 0);   verify("zero", 9'd0, 0, 1);
    check_val("zero done latency", 72'(done_cyc), 72'(s_cyc + 1));
    check_val("zero s_ready", 72'(ready_cyc - s_ready_c), 72'd0);

    run_tile(9'd7, 10'd600, 0); verify("sat", 9'd7, 512, 4097);

    run_tile(9'd20, 10'd4, 2);  verify("start busy", 9'd20, 4, 33);
    run_tile(9'd3, 10'd1, 0);   verify("restart", 9'd3, 1, 9);

    run_tile(9'd0, 10'd4, 3);
    @(posedge clk); #1;
    run_tile(9'd40, 10'd2, 0);  verify("post reset", 9'd40, 2, 17);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
